// File: rtl/ram_1r1w_sync_clr_if.sv
// Bus bundle for the single-clock 1r1w RAM: write port, read port and the
// ready / read-valid qualifiers. The master drives requests, the slave answers.
interface ram_1r1w_sync_clr_if #(
  parameter int width_p = 8,
  parameter int depth_p = 512
);
  localparam int addr_w = $clog2(depth_p);

  logic               ready_o;
  logic               wr_valid_i;
  logic [addr_w-1:0]  wr_addr_i;
  logic [width_p-1:0] wr_data_i;
  logic [width_p-1:0] wr_mask_i;
  logic               rd_valid_i;
  logic [addr_w-1:0]  rd_addr_i;
  logic               rd_valid_o;
  logic [width_p-1:0] rd_data_o;

  modport master (
    output wr_valid_i, wr_addr_i, wr_data_i, wr_mask_i, rd_valid_i, rd_addr_i,
    input  ready_o, rd_valid_o, rd_data_o
  );

  modport slave (
    input  wr_valid_i, wr_addr_i, wr_data_i, wr_mask_i, rd_valid_i, rd_addr_i,
    output ready_o, rd_valid_o, rd_data_o
  );
endinterface

// File: rtl/ram_1r1w_sync_clr.sv
// Single-clock 1-read/1-write RAM with per-bit write mask, selectable
// read-during-write behaviour and an optional zero-fill after reset.
module ram_1r1w_sync_clr #(
  parameter int width_p      = 8,
  parameter int depth_p      = 512,
  parameter int bypass_p     = 0,
  parameter int init_clear_p = 1
) (
  input logic                  clk_i,
  input logic                  reset_i,
  ram_1r1w_sync_clr_if.slave   bus
);
  localparam int addr_w = $clog2(depth_p);
  localparam logic [addr_w-1:0] last_addr = addr_w'(depth_p - 1);

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t             state;
  logic [addr_w-1:0]  clr_cnt;
  logic               ready_q;
  logic               rd_valid_q;
  logic [width_p-1:0] rd_data_q;
  logic [width_p-1:0] mem [depth_p];

  logic               wr_in_range;
  logic               rd_in_range;
  logic               wr_accept;
  logic               rd_accept;
  logic               mem_we;
  logic [addr_w-1:0]  mem_addr;
  logic [width_p-1:0] mem_data;
  logic [width_p-1:0] mem_mask;
  logic [width_p-1:0] merged;
  logic [width_p-1:0] rd_value;

  // Range checks only exist when the depth leaves unused address codes.
  generate
    if ((1 << addr_w) == depth_p) begin : g_pow2
      assign wr_in_range = 1'b1;
      assign rd_in_range = 1'b1;
    end else begin : g_npow2
      assign wr_in_range = 32'(bus.wr_addr_i) < 32'(depth_p);
      assign rd_in_range = 32'(bus.rd_addr_i) < 32'(depth_p);
    end
  endgenerate

  assign wr_accept = bus.wr_valid_i & ready_q & wr_in_range & ~reset_i;
  assign rd_accept = bus.rd_valid_i & ready_q;

  // The clear sequencer and user writes share the single write port.
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = bus.wr_addr_i;
    mem_data = bus.wr_data_i;
    mem_mask = bus.wr_mask_i;
    if (!reset_i) begin
      if (state == ST_CLEAR) begin
        mem_we   = 1'b1;
        mem_addr = clr_cnt;
        mem_data = '0;
        mem_mask = '1;
      end else if (wr_accept) begin
        mem_we = 1'b1;
      end
    end
  end

  assign merged = (mem[mem_addr] & ~mem_mask) | (mem_data & mem_mask);

  always_comb begin
    rd_value = '0;
    if (rd_in_range) begin
      if (bypass_p != 0 && wr_accept && bus.wr_addr_i == bus.rd_addr_i)
        rd_value = merged;
      else
        rd_value = mem[bus.rd_addr_i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we)
      mem[mem_addr] <= merged;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state      <= (init_clear_p != 0) ? ST_CLEAR : ST_READY;
      clr_cnt    <= '0;
      ready_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_accept;
      if (rd_accept)
        rd_data_q <= rd_value;
      case (state)
        ST_CLEAR: begin
          if (clr_cnt == last_addr) begin
            state   <= ST_READY;
            ready_q <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        ST_READY: ready_q <= 1'b1;
        default:  state   <= ST_READY;
      endcase
    end
  end

  assign bus.ready_o    = ready_q;
  assign bus.rd_valid_o = rd_valid_q;
  assign bus.rd_data_o  = rd_data_q;
endmodule

// File: tb/tb_ram_1r1w_sync_clr.sv
// Directed bench: three RAM instances (depth 16 old-data, depth 16 bypass,
// depth 10) driven in lockstep with hand-computed expected read results.
module tb_ram_1r1w_sync_clr;
  logic clk = 1'b0;
  logic reset_i;
  int   total  = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  ram_1r1w_sync_clr_if #(.width_p(8), .depth_p(16)) ia ();
  ram_1r1w_sync_clr_if #(.width_p(8), .depth_p(16)) ib ();
  ram_1r1w_sync_clr_if #(.width_p(8), .depth_p(10)) ic ();

  ram_1r1w_sync_clr #(.width_p(8), .depth_p(16), .bypass_p(0), .init_clear_p(1))
    u_a (.clk_i(clk), .reset_i(reset_i), .bus(ia));
  ram_1r1w_sync_clr #(.width_p(8), .depth_p(16), .bypass_p(1), .init_clear_p(1))
    u_b (.clk_i(clk), .reset_i(reset_i), .bus(ib));
  ram_1r1w_sync_clr #(.width_p(8), .depth_p(10), .bypass_p(0), .init_clear_p(1))
    u_c (.clk_i(clk), .reset_i(reset_i), .bus(ic));

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, act, exp);
    else
      passed++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives the same request onto all three instances, then advances one edge.
  task automatic applyStimulus(input logic wv, input logic [3:0] wa, input logic [7:0] wd,
                               input logic [7:0] wm, input logic rv, input logic [3:0] ra);
    ia.wr_valid_i = wv; ia.wr_addr_i = wa; ia.wr_data_i = wd; ia.wr_mask_i = wm;
    ia.rd_valid_i = rv; ia.rd_addr_i = ra;
    ib.wr_valid_i = wv; ib.wr_addr_i = wa; ib.wr_data_i = wd; ib.wr_mask_i = wm;
    ib.rd_valid_i = rv; ib.rd_addr_i = ra;
    ic.wr_valid_i = wv; ic.wr_addr_i = wa; ic.wr_data_i = wd; ic.wr_mask_i = wm;
    ic.rd_valid_i = rv; ic.rd_addr_i = ra;
    step();
  endtask

  task automatic idle();
    applyStimulus(1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 4'd0);
  endtask

  task automatic resetPulse();
    reset_i = 1'b1;
    idle();
    reset_i = 1'b0;
  endtask

  // Counts edges until ready rises on u_a/u_c while firing junk requests at
  // u_a/u_b; any read-valid seen during the clear is reported via saw_valid.
  task automatic waitReady(output int na, output int nc, output logic saw_valid);
    na = 0; nc = 0; saw_valid = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      ia.wr_valid_i = 1'b1; ia.wr_addr_i = 4'd9; ia.wr_data_i = 8'h77; ia.wr_mask_i = 8'hFF;
      ia.rd_valid_i = 1'b1; ia.rd_addr_i = 4'd9;
      ib.wr_valid_i = 1'b1; ib.wr_addr_i = 4'd9; ib.wr_data_i = 8'h77; ib.wr_mask_i = 8'hFF;
      ib.rd_valid_i = 1'b1; ib.rd_addr_i = 4'd9;
      ic.wr_valid_i = 1'b0; ic.rd_valid_i = 1'b0;
      step();
      if (ia.rd_valid_o || ib.rd_valid_o) saw_valid = 1'b1;
      if (ic.ready_o && nc == 0) nc = n;
      if (ia.ready_o && na == 0) begin
        na = n;
        break;
      end
    end
  endtask

  int   na, nc;
  logic sv;

  initial begin
    reset_i = 1'b1;
    idle();
    idle();
    checkOutput("reset_ready",    32'(ia.ready_o),    32'h0);
    checkOutput("reset_rd_valid", 32'(ia.rd_valid_o), 32'h0);
    checkOutput("reset_rd_data",  32'(ia.rd_data_o),  32'h0);
    reset_i = 1'b0;
    waitReady(na, nc, sv);
    checkOutput("init_clear_cycles_d16", 32'(na), 32'd16);
    checkOutput("init_clear_cycles_d10", 32'(nc), 32'd10);
    checkOutput("init_clear_no_valid",   32'(sv), 32'h0);

    // Preload, reset, and confirm the clear wiped it and ignored junk writes.
    applyStimulus(1'b1, 4'd5, 8'hA5, 8'hFF, 1'b0, 4'd0);
    applyStimulus(1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 4'd5);
    checkOutput("preload_read", 32'(ia.rd_data_o), 32'hA5);
    resetPulse();
    waitReady(na, nc, sv);
    checkOutput("clear_cycles",  32'(na), 32'd16);
    checkOutput("clear_no_valid", 32'(sv), 32'h0);
    applyStimulus(1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 4'd5);
    checkOutput("cleared_valid", 32'(ia.rd_valid_o), 32'h1);
    checkOutput("cleared_data",  32'(ia.rd_data_o),  32'h00);
    applyStimulus(1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 4'd9);
    checkOutput("junk_write_ignored", 32'(ia.rd_data_o), 32'h00);

    // Masked write: only the low nibble is zeroed.
    applyStimulus(1'b1, 4'd3, 8'hFF, 8'hFF, 1'b0, 4'd0);
    applyStimulus(1'b1, 4'd3, 8'h00, 8'h0F, 1'b0, 4'd0);
    applyStimulus(1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 4'd3);
    checkOutput("masked_write", 32'(ia.rd_data_o), 32'hF0);

    // Same-address collision: old data vs bypassed merged data.
    applyStimulus(1'b1, 4'd7, 8'h11, 8'hFF, 1'b0, 4'd0);
    applyStimulus(1'b1, 4'd7, 8'h3C, 8'hFF, 1'b1, 4'd7);
    checkOutput("collide_old",    32'(ia.rd_data_o), 32'h11);
    checkOutput("collide_bypass", 32'(ib.rd_data_o), 32'h3C);
    applyStimulus(1'b1, 4'd7, 8'h00, 8'h0F, 1'b1, 4'd7);
    checkOutput("collide_mask_old",    32'(ia.rd_data_o), 32'h3C);
    checkOutput("collide_mask_bypass", 32'(ib.rd_data_o), 32'h30);
    applyStimulus(1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 4'd7);
    checkOutput("collide_after", 32'(ia.rd_data_o), 32'h30);

    // Back-to-back reads, then an idle cycle holding the last data.
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 4'(i), 8'(8'h10 + i), 8'hFF, 1'b0, 4'd0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 4'(i));
      checkOutput($sformatf("b2b_valid%0d", i), 32'(ia.rd_valid_o), 32'h1);
      checkOutput($sformatf("b2b_data%0d", i),  32'(ia.rd_data_o),  32'(8'h10 + i));
    end
    idle();
    checkOutput("idle_valid", 32'(ia.rd_valid_o), 32'h0);
    checkOutput("idle_hold",  32'(ia.rd_data_o),  32'h13);

    // Out-of-range on the depth-10 instance; in range on depth-16.
    applyStimulus(1'b1, 4'd12, 8'h5A, 8'hFF, 1'b0, 4'd0);
    applyStimulus(1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 4'd12);
    checkOutput("oor_valid",    32'(ic.rd_valid_o), 32'h1);
    checkOutput("oor_data",     32'(ic.rd_data_o),  32'h00);
    checkOutput("inrange_data", 32'(ia.rd_data_o),  32'h5A);
    applyStimulus(1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 4'd2);
    checkOutput("oor_no_alias", 32'(ic.rd_data_o), 32'h12);

    // Reset with a pending read, then reset again partway through the clear.
    reset_i = 1'b1;
    applyStimulus(1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 4'd1);
    checkOutput("reset_drops_read", 32'(ia.rd_valid_o), 32'h0);
    checkOutput("reset_zero_data",  32'(ia.rd_data_o),  32'h0);
    reset_i = 1'b0;
    for (int i = 0; i < 6; i++) idle();
    checkOutput("midclear_not_ready", 32'(ia.ready_o), 32'h0);
    resetPulse();
    waitReady(na, nc, sv);
    checkOutput("restart_clear_cycles", 32'(na), 32'd16);
    checkOutput("restart_no_valid",     32'(sv), 32'h0);
    applyStimulus(1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 4'd3);
    checkOutput("restart_cleared", 32'(ia.rd_data_o), 32'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
